// File: rtl/nic_vc_allocator_pkg.sv
// Shared NIC constants for the VC allocator and the VC index mapping helper.
package nic_vc_allocator_pkg;

  localparam int NIC_N_OF_VC        = 2;
  localparam int NIC_N_OF_VN        = 3;
  localparam int NIC_N_TOT_OF_VC    = NIC_N_OF_VC * NIC_N_OF_VN;
  localparam int NIC_N_FIFO_BUFFER  = 4;
  localparam int NIC_N_BITS_POINTER = 2;
  localparam int NIC_N_BITS_VN      = 2;
  localparam int NIC_N_BITS_VC      = 3;

  // Global VC index of local VC 'vc' inside virtual network 'vn'.
  function automatic int vc_index(input int vn, input int vc, input int vcs_per_vn);
    return vn * vcs_per_vn + vc;
  endfunction

endpackage

// File: rtl/nic_vc_allocator_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// plus the pointer value to load when the grant is actually used.
module nic_vc_allocator_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic             advance,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] ptr_nxt
);

  // Scan requesters from ptr upward (wrapping); first hit wins.
  always_comb begin
    int   idx;
    logic found;
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        if (advance) begin
          ptr_nxt = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
        end
      end
    end
  end

endmodule

// File: rtl/nic_vc_allocator.sv
// VC allocator for the NIC-to-NoC injection path: per VN, one round-robin
// winner among the requesting buffers gets the lowest-index idle VC.
module nic_vc_allocator
  import nic_vc_allocator_pkg::*;
#(
  parameter int N_OF_VC        = NIC_N_OF_VC,
  parameter int N_OF_VN        = NIC_N_OF_VN,
  parameter int N_TOT_OF_VC    = NIC_N_TOT_OF_VC,
  parameter int N_FIFO_BUFFER  = NIC_N_FIFO_BUFFER,
  parameter int N_BITS_POINTER = NIC_N_BITS_POINTER,
  parameter int N_BITS_VN      = NIC_N_BITS_VN,
  parameter int N_BITS_VC      = NIC_N_BITS_VC
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_FIFO_BUFFER-1:0]            req_i,
  input  logic [N_FIFO_BUFFER*N_BITS_VN-1:0]  req_vn_i,
  input  logic [N_TOT_OF_VC-1:0]              fifo_pointer_state_i,
  output logic [N_TOT_OF_VC-1:0]              g_fifo_pointer_o,
  output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_o,
  output logic [N_FIFO_BUFFER-1:0]            grant_o,
  output logic [N_FIFO_BUFFER*N_BITS_VC-1:0]  granted_vc_o
);

  logic [N_OF_VN-1:0][N_FIFO_BUFFER-1:0]  elig;
  logic [N_OF_VN-1:0][N_FIFO_BUFFER-1:0]  arb_grant;
  logic [N_OF_VN-1:0]                     any_vc;
  logic [N_OF_VN-1:0]                     advance;
  logic [N_OF_VN-1:0][N_BITS_VC-1:0]      vc_sel;
  logic [N_OF_VN-1:0][N_BITS_POINTER-1:0] rr_ptr;
  logic [N_OF_VN-1:0][N_BITS_POINTER-1:0] rr_ptr_nxt;

  logic [N_TOT_OF_VC-1:0]                 g_ptr_nxt;
  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0]  id_nxt;
  logic [N_FIFO_BUFFER-1:0]               grant_nxt;
  logic [N_FIFO_BUFFER*N_BITS_VC-1:0]     granted_vc_nxt;

  // Eligible requesters and lowest-index available VC per VN. Requests and VCs
  // granted in the current cycle are masked because the requester has not yet
  // dropped req_i and the pointer FIFO status lags one cycle.
  always_comb begin
    elig    = '0;
    any_vc  = '0;
    vc_sel  = '0;
    advance = '0;
    for (int v = 0; v < N_OF_VN; v++) begin
      for (int b = 0; b < N_FIFO_BUFFER; b++) begin
        elig[v][b] = req_i[b] && !grant_o[b] &&
                     (int'(req_vn_i[b*N_BITS_VN +: N_BITS_VN]) == v);
      end
      for (int c = N_OF_VC - 1; c >= 0; c--) begin
        if (!fifo_pointer_state_i[vc_index(v, c, N_OF_VC)] &&
            !g_fifo_pointer_o[vc_index(v, c, N_OF_VC)]) begin
          any_vc[v] = 1'b1;
          vc_sel[v] = N_BITS_VC'(vc_index(v, c, N_OF_VC));
        end
      end
      advance[v] = (|elig[v]) && any_vc[v];
    end
  end

  for (genvar v = 0; v < N_OF_VN; v++) begin : g_arb
    nic_vc_allocator_rr_arbiter #(
      .N     (N_FIFO_BUFFER),
      .PTR_W (N_BITS_POINTER)
    ) u_arb (
      .req     (elig[v]),
      .advance (advance[v]),
      .ptr     (rr_ptr[v]),
      .grant   (arb_grant[v]),
      .ptr_nxt (rr_ptr_nxt[v])
    );
  end

  // Map each VN's winner and chosen VC onto the buffer-side and VC-side outputs.
  always_comb begin
    int gvc;
    g_ptr_nxt      = '0;
    id_nxt         = '0;
    grant_nxt      = '0;
    granted_vc_nxt = '0;
    gvc            = 0;
    for (int v = 0; v < N_OF_VN; v++) begin
      for (int b = 0; b < N_FIFO_BUFFER; b++) begin
        if (advance[v] && arb_grant[v][b]) begin
          gvc                                        = int'(vc_sel[v]);
          grant_nxt[b]                               = 1'b1;
          granted_vc_nxt[b*N_BITS_VC +: N_BITS_VC]   = vc_sel[v];
          g_ptr_nxt[vc_sel[v]]                       = 1'b1;
          id_nxt[gvc*N_BITS_POINTER +: N_BITS_POINTER] = N_BITS_POINTER'(b);
        end
      end
    end
  end

  // Stage boundary: registered grant outputs and round-robin pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_fifo_pointer_o       <= '0;
      g_fifo_out_buffer_id_o <= '0;
      grant_o                <= '0;
      granted_vc_o           <= '0;
      rr_ptr                 <= '0;
    end else begin
      g_fifo_pointer_o       <= g_ptr_nxt;
      g_fifo_out_buffer_id_o <= id_nxt;
      grant_o                <= grant_nxt;
      granted_vc_o           <= granted_vc_nxt;
      rr_ptr                 <= rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_nic_vc_allocator.sv
// Directed bench for nic_vc_allocator with an expected-output scoreboard.
module tb_nic_vc_allocator;

  logic        clk;
  logic        rst;
  logic [3:0]  req_i;
  logic [7:0]  req_vn_i;
  logic [5:0]  fifo_pointer_state_i;
  logic [5:0]  g_fifo_pointer_o;
  logic [11:0] g_fifo_out_buffer_id_o;
  logic [3:0]  grant_o;
  logic [11:0] granted_vc_o;

  typedef struct packed {
    logic [3:0]  grant;
    logic [11:0] gvc;
    logic [5:0]  gptr;
    logic [11:0] ids;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  nic_vc_allocator dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_i                  (req_i),
    .req_vn_i               (req_vn_i),
    .fifo_pointer_state_i   (fifo_pointer_state_i),
    .g_fifo_pointer_o       (g_fifo_pointer_o),
    .g_fifo_out_buffer_id_o (g_fifo_out_buffer_id_o),
    .grant_o                (grant_o),
    .granted_vc_o           (granted_vc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // granted_vc_o value with field b set to vc
  function automatic logic [11:0] vf(input int b, input int vc);
    logic [11:0] r;
    r = '0;
    r[b*3 +: 3] = 3'(vc);
    return r;
  endfunction

  // g_fifo_out_buffer_id_o value with field vc set to buffer b
  function automatic logic [11:0] idf(input int vc, input int b);
    logic [11:0] r;
    r = '0;
    r[vc*2 +: 2] = 2'(b);
    return r;
  endfunction

  task automatic step(input logic r, input logic [3:0] rq, input logic [7:0] vn,
                      input logic [5:0] st, input logic [3:0] eg, input logic [11:0] ev,
                      input logic [5:0] ep, input logic [11:0] ei, input string tag);
    exp_t e;
    rst                  = r;
    req_i                = rq;
    req_vn_i             = vn;
    fifo_pointer_state_i = st;
    sb.push_back('{grant: eg, gvc: ev, gptr: ep, ids: ei});
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (grant_o === e.grant) else begin
        errors++;
        $error("FAIL %s grant_o observed=%b expected=%b", tag, grant_o, e.grant);
      end
      checks++;
      assert (granted_vc_o === e.gvc) else begin
        errors++;
        $error("FAIL %s granted_vc_o observed=%h expected=%h", tag, granted_vc_o, e.gvc);
      end
      checks++;
      assert (g_fifo_pointer_o === e.gptr) else begin
        errors++;
        $error("FAIL %s g_fifo_pointer_o observed=%b expected=%b", tag, g_fifo_pointer_o, e.gptr);
      end
      checks++;
      assert (g_fifo_out_buffer_id_o === e.ids) else begin
        errors++;
        $error("FAIL %s buffer_id observed=%h expected=%h", tag, g_fifo_out_buffer_id_o, e.ids);
      end
    end
  endtask

  task automatic chk_rr(input int v, input logic [1:0] exp, input string tag);
    logic [1:0] obs;
    obs = dut.rr_ptr[v];
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s rr_ptr[%0d] observed=%0d expected=%0d", tag, v, obs, exp);
    end
  endtask

  task automatic idle(input string tag);
    step(1'b0, 4'b0000, 8'h00, 6'b000000, 4'b0000, 12'h000, 6'b000000, 12'h000, tag);
  endtask

  initial begin
    rst = 1'b1;
    req_i = '0;
    req_vn_i = '0;
    fifo_pointer_state_i = '0;

    // Reset
    step(1'b1, 4'b0000, 8'h00, 6'b0, 4'b0, 12'h0, 6'b0, 12'h0, "reset_a");
    step(1'b1, 4'b0000, 8'h00, 6'b0, 4'b0, 12'h0, 6'b0, 12'h0, "reset_b");
    chk_rr(0, 2'd0, "reset");
    chk_rr(1, 2'd0, "reset");
    chk_rr(2, 2'd0, "reset");

    // Single request: buffer 2 on VN1
    step(1'b0, 4'b0100, 8'h10, 6'b0, 4'b0100, vf(2, 2), 6'b000100, idf(2, 2), "t1_grant");
    idle("t1_after");
    chk_rr(1, 2'd3, "t1");

    // Buffers 0,1,3 contend on VN0, status follows grants one cycle late
    step(1'b0, 4'b1011, 8'h00, 6'b000000, 4'b0001, vf(0, 0), 6'b000001, idf(0, 0), "t2_g0");
    step(1'b0, 4'b1011, 8'h00, 6'b000000, 4'b0010, vf(1, 1), 6'b000010, idf(1, 1), "t2_g1");
    step(1'b0, 4'b1011, 8'h00, 6'b000001, 4'b0, 12'h0, 6'b0, 12'h0, "t2_full_a");
    step(1'b0, 4'b1011, 8'h00, 6'b000011, 4'b0, 12'h0, 6'b0, 12'h0, "t2_full_b");
    step(1'b0, 4'b1011, 8'h00, 6'b000011, 4'b0, 12'h0, 6'b0, 12'h0, "t2_full_c");
    chk_rr(0, 2'd2, "t2_hold");
    step(1'b0, 4'b1011, 8'h00, 6'b000000, 4'b1000, vf(3, 0), 6'b000001, idf(0, 3), "t2_g3");
    step(1'b0, 4'b1011, 8'h00, 6'b000000, 4'b0001, vf(0, 1), 6'b000010, idf(1, 0), "t2_g0b");
    chk_rr(0, 2'd1, "t2_rot");
    idle("t2_after");

    // VN0 fully busy: buffer 1 waits, then VC1 frees up
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'b0010, 8'h00, 6'b000011, 4'b0, 12'h0, 6'b0, 12'h0, "t3_wait");
    step(1'b0, 4'b0010, 8'h00, 6'b000001, 4'b0010, vf(1, 1), 6'b000010, idf(1, 1), "t3_grant");
    chk_rr(0, 2'd2, "t3");
    idle("t3_after");

    // Three VNs grant in the same cycle
    step(1'b0, 4'b0111, 8'h24, 6'b0, 4'b0111, vf(0, 0) | vf(1, 2) | vf(2, 4),
         6'b010101, idf(0, 0) | idf(2, 1) | idf(4, 2), "t4_multi");
    idle("t4_after");
    chk_rr(0, 2'd1, "t4");
    chk_rr(1, 2'd2, "t4");
    chk_rr(2, 2'd3, "t4");

    // Held request with lagging status: no VC0 regrant, then VC1
    step(1'b0, 4'b0001, 8'h00, 6'b000000, 4'b0001, vf(0, 0), 6'b000001, idf(0, 0), "t5_t1");
    step(1'b0, 4'b0001, 8'h00, 6'b000000, 4'b0, 12'h0, 6'b0, 12'h0, "t5_t2");
    step(1'b0, 4'b0001, 8'h00, 6'b000001, 4'b0001, vf(0, 1), 6'b000010, idf(1, 0), "t5_t3");
    idle("t5_after");

    // Reset during the grant cycle, held request re-arbitrated afterwards
    step(1'b0, 4'b1000, 8'h80, 6'b0, 4'b1000, vf(3, 4), 6'b010000, idf(4, 3), "t6_grant");
    step(1'b1, 4'b1000, 8'h80, 6'b0, 4'b0, 12'h0, 6'b0, 12'h0, "t6_reset");
    chk_rr(0, 2'd0, "t6_reset");
    chk_rr(1, 2'd0, "t6_reset");
    chk_rr(2, 2'd0, "t6_reset");
    step(1'b0, 4'b1000, 8'h80, 6'b0, 4'b1000, vf(3, 4), 6'b010000, idf(4, 3), "t6_rearb");
    idle("t6_after");

    // Out-of-range VN is never granted
    for (int i = 0; i < 3; i++)
      step(1'b0, 4'b0010, 8'h0C, 6'b0, 4'b0, 12'h0, 6'b0, 12'h0, "t7_bad_vn");
    idle("t7_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
